// File: rtl/tt_sweep_pkg.sv
// Shared types and sizing helpers for the truth-table sweeper.
// Holds the FSM state encoding and the hold-timer width function.
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N_IN_DEF = 3;
  localparam int TT_W     = 2**N_IN_DEF;
  localparam int HOLD_DEF = 50;

  function automatic int tmr_w(input int hold);
    return (hold < 1) ? 1 : $clog2(hold + 1);
  endfunction

  localparam int TMR_W = tmr_w(HOLD_DEF);

endpackage

// File: rtl/tt_sweeper_if.sv
// Stimulus/response bundle between the sweeper and its environment.
// master = environment side, slave = sweeper side.
interface tt_sweeper_if #(
  parameter int N_IN = 3
);
  localparam int TW = 1 << N_IN;

  logic            start;
  logic            f_in;
  logic [N_IN-1:0] stim;
  logic            busy;
  logic            done;
  logic            pass;
  logic [TW-1:0]   table_out;

  modport master (
    output start,
    output f_in,
    input  stim,
    input  busy,
    input  done,
    input  pass,
    input  table_out
  );

  modport slave (
    input  start,
    input  f_in,
    output stim,
    output busy,
    output done,
    output pass,
    output table_out
  );

endinterface

// File: rtl/tt_hold_timer.sv
// Loadable down-counter; zero flags the last clock of a vector hold.
// Counts to zero and parks there until reloaded.
module tt_hold_timer
  import tt_sweep_pkg::*;
#(
  parameter int HOLD_CYCLES = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic zero
);

  localparam int W = tmr_w(HOLD_CYCLES);
  localparam logic [W-1:0] LD = W'(HOLD_CYCLES - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= LD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign zero = (r_cnt == '0);

endmodule

// File: rtl/tt_sweeper.sv
// Clocked driver/checker sweeping all inputs of a 3-input function.
// Optional TT_FIRST_FAIL_EN adds first_fail/fail_seen mismatch tracking.
module tt_sweeper
  import tt_sweep_pkg::*;
#(
  parameter int                    N_IN        = 3,
  parameter int                    HOLD_CYCLES = 50,
  parameter logic [(1<<N_IN)-1:0]  EXPECTED    = 8'hCE
) (
  input  logic            clk,
  input  logic            rst,
  tt_sweeper_if.slave     bus
`ifdef TT_FIRST_FAIL_EN
  ,
  output logic [N_IN-1:0] first_fail,
  output logic            fail_seen
`endif
);

  localparam int TW = 1 << N_IN;
  localparam logic [N_IN-1:0] IDX_MAX = '1;

  state_t          r_st, w_st_n;
  logic [N_IN-1:0] r_idx, w_idx_n;
  logic [TW-1:0]   r_tbl, w_tbl_n, w_tbl_smp;
  logic            r_busy, w_busy_n;
  logic            r_done, w_done_n;
  logic            r_pass, w_pass_n;
  logic            r_start;
  logic            w_load;
  logic            w_zero;

  // start is registered so the sweep begins the clock after it is sampled
  always_ff @(posedge clk) begin
    if (rst) r_start <= 1'b0;
    else     r_start <= bus.start;
  end

  tt_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_tmr (
    .clk  (clk),
    .rst  (rst),
    .load (w_load),
    .zero (w_zero)
  );

  assign w_tbl_smp = r_tbl | (TW'(bus.f_in) << r_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st   <= IDLE;
      r_idx  <= '0;
      r_tbl  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else begin
      r_st   <= w_st_n;
      r_idx  <= w_idx_n;
      r_tbl  <= w_tbl_n;
      r_busy <= w_busy_n;
      r_done <= w_done_n;
      r_pass <= w_pass_n;
    end
  end

  always_comb begin
    w_st_n   = r_st;
    w_idx_n  = r_idx;
    w_tbl_n  = r_tbl;
    w_busy_n = r_busy;
    w_done_n = r_done;
    w_pass_n = r_pass;
    w_load   = 1'b0;
    unique case (r_st)
      IDLE, DONE: begin
        if (r_start) begin
          w_st_n   = HOLD;
          w_idx_n  = '0;
          w_tbl_n  = '0;
          w_busy_n = 1'b1;
          w_done_n = 1'b0;
          w_pass_n = 1'b0;
          w_load   = 1'b1;
        end
      end
      HOLD: begin
        if (w_zero) begin
          w_tbl_n = w_tbl_smp;
          if (r_idx == IDX_MAX) begin
            w_st_n   = DONE;
            w_idx_n  = '0;
            w_busy_n = 1'b0;
            w_done_n = 1'b1;
            w_pass_n = (w_tbl_smp == EXPECTED);
          end else begin
            w_idx_n = r_idx + N_IN'(1);
            w_load  = 1'b1;
          end
        end
      end
      default: begin
        w_st_n = IDLE;
      end
    endcase
  end

  assign bus.stim      = r_idx;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.table_out = r_tbl;

`ifdef TT_FIRST_FAIL_EN
  logic [N_IN-1:0] r_ff;
  logic            r_fs;
  logic            w_clr;
  logic            w_miss;

  assign w_clr  = (r_st != HOLD) && r_start;
  assign w_miss = (r_st == HOLD) && w_zero &&
                  (bus.f_in != EXPECTED[r_idx]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ff <= '0;
      r_fs <= 1'b0;
    end else if (w_clr) begin
      r_ff <= '0;
      r_fs <= 1'b0;
    end else if (w_miss && !r_fs) begin
      r_ff <= r_idx;
      r_fs <= 1'b1;
    end
  end

  assign first_fail = r_ff;
  assign fail_seen  = r_fs;
`endif

endmodule

// File: tb/tb_tt_sweeper.sv
// Directed bench for tt_sweeper: default hold and a HOLD_CYCLES=1 copy.
// Expected tables, latencies and stim sequences are computed by hand.
module tb_tt_sweeper;

  localparam logic [7:0] GOLD = 8'hCE;
  localparam int         HC   = 50;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  logic [7:0] model;
  logic [7:0] model_b;

  always #5 clk = ~clk;

  tt_sweeper_if #(.N_IN(3)) ifa ();
  tt_sweeper_if #(.N_IN(3)) ifb ();

  assign ifa.f_in = model[ifa.stim];
  assign ifb.f_in = model_b[ifb.stim];

`ifdef TT_FIRST_FAIL_EN
  logic [2:0] ff_a, ff_b;
  logic       fs_a, fs_b;
`endif

  tt_sweeper #(
    .N_IN(3), .HOLD_CYCLES(HC), .EXPECTED(GOLD)
  ) u_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
`ifdef TT_FIRST_FAIL_EN
    ,
    .first_fail (ff_a),
    .fail_seen  (fs_a)
`endif
  );

  tt_sweeper #(
    .N_IN(3), .HOLD_CYCLES(1), .EXPECTED(GOLD)
  ) u_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
`ifdef TT_FIRST_FAIL_EN
    ,
    .first_fail (ff_b),
    .fail_seen  (fs_b)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full sweep on DUT A with function m; optional ignored start at vector 3
  task automatic sweep_a(input logic [7:0] m, input bit inj,
                         input string tag);
    int lat;
    int serr;
    int fi;
    lat = -1;
    serr = 0;
    fi = -1;
    model = m;
    ifa.start = 1'b1;
    tick;
    ifa.start = 1'b0;
    for (int k = 1; k <= 600; k++) begin
      tick;
      if (k == 1) begin
        chk({tag, "_busy1"}, 32'(ifa.busy), 1);
        chk({tag, "_done_clr"}, 32'(ifa.done), 0);
        chk({tag, "_pass_clr"}, 32'(ifa.pass), 0);
      end
      if (k == 1 + 2*HC)
        chk({tag, "_part"}, 32'(ifa.table_out), 32'(m & 8'h03));
      if (ifa.done) begin
        lat = k;
        break;
      end
      if (ifa.stim != 3'((k - 1) / HC)) serr++;
      ifa.start = inj && (k == 3*HC + 5);
    end
    ifa.start = 1'b0;
    chk({tag, "_lat"}, 32'(lat), 401);
    chk({tag, "_stim_seq"}, 32'(serr), 0);
    chk({tag, "_table"}, 32'(ifa.table_out), 32'(m));
    chk({tag, "_pass"}, 32'(ifa.pass), 32'(m == GOLD));
    chk({tag, "_busy0"}, 32'(ifa.busy), 0);
    chk({tag, "_stim0"}, 32'(ifa.stim), 0);
    for (int i = 7; i >= 0; i--)
      if (m[i] != GOLD[i]) fi = i;
`ifdef TT_FIRST_FAIL_EN
    chk({tag, "_fail_seen"}, 32'(fs_a), 32'(fi >= 0));
    chk({tag, "_first_fail"}, 32'(ff_a), (fi >= 0) ? 32'(fi) : 0);
`endif
  endtask

  initial begin
    int lat;
    int serr;
    rst = 1'b1;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    model = GOLD;
    model_b = GOLD;
    tick;
    tick;
    rst = 1'b0;
    tick;
    chk("rst_stim", 32'(ifa.stim), 0);
    chk("rst_busy", 32'(ifa.busy), 0);
    chk("rst_done", 32'(ifa.done), 0);
    chk("rst_pass", 32'(ifa.pass), 0);
    chk("rst_table", 32'(ifa.table_out), 0);

    sweep_a(GOLD, 1'b0, "good");
    sweep_a(GOLD, 1'b0, "restart");
    sweep_a(8'h00, 1'b0, "zero");
    sweep_a(8'h4E, 1'b0, "bit7");
    sweep_a(GOLD, 1'b1, "dblstart");

    // reset while vector 4 is held, then a clean restart
    model = GOLD;
    ifa.start = 1'b1;
    tick;
    ifa.start = 1'b0;
    repeat (1 + 4*HC + 3) tick;
    chk("pre_rst_stim", 32'(ifa.stim), 4);
    rst = 1'b1;
    tick;
    chk("midrst_stim", 32'(ifa.stim), 0);
    chk("midrst_busy", 32'(ifa.busy), 0);
    chk("midrst_done", 32'(ifa.done), 0);
    chk("midrst_table", 32'(ifa.table_out), 0);
    rst = 1'b0;
    tick;
    sweep_a(GOLD, 1'b0, "after_rst");

    // HOLD_CYCLES=1 instance
    lat = -1;
    serr = 0;
    ifb.start = 1'b1;
    tick;
    ifb.start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick;
      if (ifb.done) begin
        lat = k;
        break;
      end
      if (ifb.stim != 3'(k - 1)) serr++;
    end
    chk("h1_lat", 32'(lat), 9);
    chk("h1_stim_seq", 32'(serr), 0);
    chk("h1_table", 32'(ifb.table_out), 32'(GOLD));
    chk("h1_pass", 32'(ifb.pass), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
